// File: rtl/spi_tx_arbiter_pkg.sv
// Shared SPI transmit constants, state/owner encodings and the slot grant decision.
package spi_tx_arbiter_pkg;

  localparam int SPI_SDEPTH = 8;
  localparam int SPI_CWIDTH = 4;

  localparam logic [SPI_SDEPTH-1:0] SPI_IDLE_FILL = 8'hFF;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RSP  = 2'b01;
  localparam logic [1:0] ST_DAT  = 2'b10;

  localparam logic [1:0] OWN_IDLE = 2'b00;
  localparam logic [1:0] OWN_RSP  = 2'b01;
  localparam logic [1:0] OWN_DAT  = 2'b10;

  typedef struct packed {
    logic [1:0] nxt_state;
    logic       take_rsp;
    logic       take_dat;
    logic       underrun;
  } arb_dec_t;

  // Decision for one slot. fair_hit means RSP has used up its run while DAT waits.
  function automatic arb_dec_t arb_decide(input logic [1:0] state,
                                          input logic       rsp_v,
                                          input logic       rsp_l,
                                          input logic       dat_v,
                                          input logic       dat_l,
                                          input logic       fair_hit);
    arb_dec_t d;
    d           = '0;
    d.nxt_state = state;
    case (state)
      ST_IDLE: begin
        if (rsp_v && !(dat_v && fair_hit)) begin
          d.take_rsp  = 1'b1;
          d.nxt_state = rsp_l ? ST_IDLE : ST_RSP;
        end else if (dat_v) begin
          d.take_dat  = 1'b1;
          d.nxt_state = dat_l ? ST_IDLE : ST_DAT;
        end
      end
      ST_RSP: begin
        if (rsp_v) begin
          d.take_rsp  = 1'b1;
          d.nxt_state = rsp_l ? ST_IDLE : ST_RSP;
        end else begin
          d.underrun  = 1'b1;
        end
      end
      ST_DAT: begin
        if (dat_v) begin
          d.take_dat  = 1'b1;
          d.nxt_state = dat_l ? ST_IDLE : ST_DAT;
        end else begin
          d.underrun  = 1'b1;
        end
      end
      default: d.nxt_state = ST_IDLE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter.sv
// Arbitrates response and data byte streams onto the shared SPI shift-out register,
// one byte per shifter slot, with packet-level ownership and a fairness cap for RSP.
module spi_tx_arbiter
  import spi_tx_arbiter_pkg::*;
#(
  parameter int SDEPTH   = SPI_SDEPTH,
  parameter int FAIR_MAX = 4
) (
  input  logic              SPI_Clk,
  input  logic              SPI_ResetN,
  input  logic              SPI_AlmostEmptyN,
  output logic              SPI_Data_RdyN,
  output logic [SDEPTH-1:0] SPI_Data_Out,
  input  logic              Rsp_Valid,
  input  logic              Rsp_Last,
  input  logic [SDEPTH-1:0] Rsp_Data,
  output logic              Rsp_Ack,
  input  logic              Dat_Valid,
  input  logic              Dat_Last,
  input  logic [SDEPTH-1:0] Dat_Data,
  output logic              Dat_Ack,
  output logic [1:0]        Tx_Owner,
  output logic              Tx_Underrun
);

  localparam logic [SDEPTH-1:0]     FILL     = SDEPTH'(SPI_IDLE_FILL);
  localparam logic [SPI_CWIDTH-1:0] FAIR_LIM = SPI_CWIDTH'(FAIR_MAX);

  logic [1:0]            state;
  logic [SPI_CWIDTH-1:0] fair_cnt;
  logic                  load_q;
  logic                  slot;
  arb_dec_t              dec;
  logic [SDEPTH-1:0]     nxt_byte;
  logic [SPI_CWIDTH-1:0] nxt_cnt;

  // A slot is taken only while no load is in flight, so a long low on
  // AlmostEmptyN cannot produce two back-to-back strobes.
  assign slot = !SPI_AlmostEmptyN && !load_q;

  always_comb begin
    dec      = arb_decide(state, Rsp_Valid, Rsp_Last, Dat_Valid, Dat_Last,
                          fair_cnt >= FAIR_LIM);
    nxt_byte = FILL;
    nxt_cnt  = fair_cnt;
    if (dec.take_rsp)      nxt_byte = Rsp_Data;
    else if (dec.take_dat) nxt_byte = Dat_Data;
    // Fairness only counts packet grants, which happen in IDLE.
    if (state == ST_IDLE) begin
      if (dec.take_dat)      nxt_cnt = '0;
      else if (dec.take_rsp) nxt_cnt = Dat_Valid ? fair_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge SPI_Clk or negedge SPI_ResetN) begin
    if (!SPI_ResetN) begin
      state        <= ST_IDLE;
      fair_cnt     <= '0;
      load_q       <= 1'b0;
      SPI_Data_Out <= FILL;
      Rsp_Ack      <= 1'b0;
      Dat_Ack      <= 1'b0;
      Tx_Underrun  <= 1'b0;
    end else begin
      load_q      <= slot;
      Rsp_Ack     <= slot && dec.take_rsp;
      Dat_Ack     <= slot && dec.take_dat;
      Tx_Underrun <= slot && dec.underrun;
      if (slot) begin
        state        <= dec.nxt_state;
        fair_cnt     <= nxt_cnt;
        SPI_Data_Out <= nxt_byte;
      end
    end
  end

  assign SPI_Data_RdyN = !load_q;

  always_comb begin
    case (state)
      ST_RSP:  Tx_Owner = OWN_RSP;
      ST_DAT:  Tx_Owner = OWN_DAT;
      default: Tx_Owner = OWN_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: queued source packets, slot pulses from the
// main sequence, and a scoreboard of expected loads checked on every strobe.
module tb_spi_tx_arbiter;

  logic       SPI_Clk;
  logic       SPI_ResetN;
  logic       SPI_AlmostEmptyN;
  logic       SPI_Data_RdyN;
  logic [7:0] SPI_Data_Out;
  logic       Rsp_Valid, Rsp_Last, Rsp_Ack;
  logic [7:0] Rsp_Data;
  logic       Dat_Valid, Dat_Last, Dat_Ack;
  logic [7:0] Dat_Data;
  logic [1:0] Tx_Owner;
  logic       Tx_Underrun;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } byte_t;

  typedef struct {
    logic [7:0] data;
    logic       rack;
    logic       dack;
    logic       urun;
    logic [1:0] owner;
  } exp_t;

  byte_t rsp_q[$];
  byte_t dat_q[$];
  exp_t  exp_q[$];
  logic  dat_hold;
  string cur_step;
  int    tests;
  int    fails;

  spi_tx_arbiter #(.SDEPTH(8), .FAIR_MAX(4)) dut (
    .SPI_Clk          (SPI_Clk),
    .SPI_ResetN       (SPI_ResetN),
    .SPI_AlmostEmptyN (SPI_AlmostEmptyN),
    .SPI_Data_RdyN    (SPI_Data_RdyN),
    .SPI_Data_Out     (SPI_Data_Out),
    .Rsp_Valid        (Rsp_Valid),
    .Rsp_Last         (Rsp_Last),
    .Rsp_Data         (Rsp_Data),
    .Rsp_Ack          (Rsp_Ack),
    .Dat_Valid        (Dat_Valid),
    .Dat_Last         (Dat_Last),
    .Dat_Data         (Dat_Data),
    .Dat_Ack          (Dat_Ack),
    .Tx_Owner         (Tx_Owner),
    .Tx_Underrun      (Tx_Underrun)
  );

  initial SPI_Clk = 1'b0;
  always #5 SPI_Clk = ~SPI_Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic ra, input logic da,
                          input logic ur, input logic [1:0] own);
    exp_t e;
    e.data = d; e.rack = ra; e.dack = da; e.urun = ur; e.owner = own;
    exp_q.push_back(e);
  endtask

  task automatic push_rsp(input logic [7:0] d, input logic l);
    byte_t b;
    b.data = d; b.last = l;
    rsp_q.push_back(b);
  endtask

  task automatic push_dat(input logic [7:0] d, input logic l);
    byte_t b;
    b.data = d; b.last = l;
    dat_q.push_back(b);
  endtask

  // One slot per 8-clock byte period: AlmostEmptyN low for a single cycle.
  task automatic do_slots(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge SPI_Clk);
      SPI_AlmostEmptyN = 1'b0;
      @(negedge SPI_Clk);
      SPI_AlmostEmptyN = 1'b1;
      repeat (6) @(negedge SPI_Clk);
    end
  endtask

  task automatic drain_check();
    repeat (2) @(negedge SPI_Clk);
    check({cur_step, ".pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Source models: present the queue head, retire it on that source's Ack.
  always @(negedge SPI_Clk) begin
    if (Rsp_Ack && rsp_q.size() > 0) void'(rsp_q.pop_front());
    if (Dat_Ack && dat_q.size() > 0) void'(dat_q.pop_front());
    Rsp_Valid = rsp_q.size() > 0;
    Rsp_Data  = (rsp_q.size() > 0) ? rsp_q[0].data : 8'h00;
    Rsp_Last  = (rsp_q.size() > 0) ? rsp_q[0].last : 1'b0;
    Dat_Valid = (dat_q.size() > 0) && !dat_hold;
    Dat_Data  = (dat_q.size() > 0) ? dat_q[0].data : 8'h00;
    Dat_Last  = (dat_q.size() > 0) ? dat_q[0].last : 1'b0;
  end

  // Scoreboard: every strobe must match the next expected load; no strobes otherwise.
  always @(negedge SPI_Clk) begin
    exp_t e;
    if (SPI_ResetN) begin
      if (!SPI_Data_RdyN) begin
        if (exp_q.size() == 0) begin
          check({cur_step, ".unexpected_load"}, {24'h0, SPI_Data_Out}, 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check({cur_step, ".data"},    SPI_Data_Out, e.data);
          check({cur_step, ".rsp_ack"}, Rsp_Ack,      e.rack);
          check({cur_step, ".dat_ack"}, Dat_Ack,      e.dack);
          check({cur_step, ".underrun"},Tx_Underrun,  e.urun);
          check({cur_step, ".owner"},   Tx_Owner,     e.owner);
        end
      end else begin
        check({cur_step, ".quiet"}, {Rsp_Ack, Dat_Ack, Tx_Underrun}, 3'b000);
      end
    end
  end

  initial begin
    tests = 0; fails = 0;
    cur_step = "reset";
    dat_hold = 1'b0;
    SPI_ResetN = 1'b0;
    SPI_AlmostEmptyN = 1'b1;
    Rsp_Valid = 0; Rsp_Last = 0; Rsp_Data = 0;
    Dat_Valid = 0; Dat_Last = 0; Dat_Data = 0;
    repeat (3) @(negedge SPI_Clk);
    check("reset.rdyn",  SPI_Data_RdyN, 1'b1);
    check("reset.data",  SPI_Data_Out,  8'hFF);
    check("reset.owner", Tx_Owner,      2'b00);
    check("reset.acks",  {Rsp_Ack, Dat_Ack, Tx_Underrun}, 3'b000);
    SPI_ResetN = 1'b1;
    @(negedge SPI_Clk);

    cur_step = "idle_fill";
    repeat (3) push_exp(8'hFF, 0, 0, 0, 2'b00);
    do_slots(3);
    drain_check();

    cur_step = "rsp_pkt";
    push_rsp(8'hA1, 0); push_rsp(8'hA2, 0); push_rsp(8'hA3, 1);
    push_exp(8'hA1, 1, 0, 0, 2'b01);
    push_exp(8'hA2, 1, 0, 0, 2'b01);
    push_exp(8'hA3, 1, 0, 0, 2'b00);
    do_slots(3);
    drain_check();

    cur_step = "both_valid";
    push_dat(8'hD1, 0); push_dat(8'hD2, 1);
    push_rsp(8'hB1, 1);
    push_exp(8'hB1, 1, 0, 0, 2'b00);
    push_exp(8'hD1, 0, 1, 0, 2'b10);
    push_exp(8'hD2, 0, 1, 0, 2'b00);
    do_slots(3);
    drain_check();

    cur_step = "fairness";
    for (int i = 0; i < 6; i++) push_rsp(8'hC0 + 8'(i), 1);
    push_dat(8'hE1, 0); push_dat(8'hE2, 1);
    for (int i = 0; i < 4; i++) push_exp(8'hC0 + 8'(i), 1, 0, 0, 2'b00);
    push_exp(8'hE1, 0, 1, 0, 2'b10);
    push_exp(8'hE2, 0, 1, 0, 2'b00);
    push_exp(8'hC4, 1, 0, 0, 2'b00);
    push_exp(8'hC5, 1, 0, 0, 2'b00);
    do_slots(8);
    drain_check();

    cur_step = "underrun";
    push_dat(8'h51, 0); push_dat(8'h52, 0); push_dat(8'h53, 1);
    push_exp(8'h51, 0, 1, 0, 2'b10);
    do_slots(1);
    dat_hold = 1'b1;
    push_exp(8'hFF, 0, 0, 1, 2'b10);
    do_slots(1);
    dat_hold = 1'b0;
    push_exp(8'h52, 0, 1, 0, 2'b10);
    push_exp(8'h53, 0, 1, 0, 2'b00);
    do_slots(2);
    drain_check();

    cur_step = "reset_mid";
    push_rsp(8'h61, 0); push_rsp(8'h62, 0); push_rsp(8'h63, 1);
    push_exp(8'h61, 1, 0, 0, 2'b01);
    do_slots(1);
    #3 SPI_ResetN = 1'b0;
    #1;
    check("reset_mid.rdyn",  SPI_Data_RdyN, 1'b1);
    check("reset_mid.data",  SPI_Data_Out,  8'hFF);
    check("reset_mid.owner", Tx_Owner,      2'b00);
    check("reset_mid.acks",  {Rsp_Ack, Dat_Ack, Tx_Underrun}, 3'b000);
    rsp_q.delete();
    push_dat(8'h71, 1);
    repeat (2) @(negedge SPI_Clk);
    SPI_ResetN = 1'b1;
    push_exp(8'h71, 0, 1, 0, 2'b00);
    do_slots(1);
    drain_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
